apb_req_arbiter: RTL and testbench

- Two-requester APB master that shares the single register-file APB slave (control register at 0x0, data registers at 0x4–0x10) between two on-chip requesters.
- Accepts one request at a time with round-robin arbitration and runs a full APB SETUP/ACCESS sequence.
- The slave has no `pready` and presents read data one cycle after ACCESS, so the block waits that cycle, captures `prdata`, and returns a per-requester response.

---
 rtl/apb_req_arbiter_if.sv | 22 ++
 rtl/apb_req_arbiter.sv | 147 ++++++++++++++
 tb/tb_apb_req_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/apb_req_arbiter_if.sv
// rtl/apb_req_arbiter_if.sv - APB bus between the request arbiter and the register-file slave
interface apb_req_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] prdata;

    modport master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata
    );

    modport slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - two-requester round-robin APB master; optional APB_ARB_ADDR_CHECK_EN rejects bad addresses
module apb_req_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_rsp_valid,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    apb_req_arbiter_if.master apb
);

`ifdef APB_ARB_ADDR_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_CAPTURE, S_RESP, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_CAPTURE, S_RESP} state_t;
`endif

    state_t            state;
    state_t            next_state;
    logic              owner;
    logic              last_grant;
    logic              elig0;
    logic              elig1;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
`ifdef APB_ARB_ADDR_CHECK_EN
    logic              req_bad;
`endif

    // RESP also accepts, but only from the requester not being answered,
    // so back-to-back contention runs one transaction every four cycles.
    always_comb begin
        elig0  = 1'b0;
        elig1  = 1'b0;
        if (!preset && (state == S_IDLE || state == S_RESP)) begin
            elig0 = r0_valid && !(state == S_RESP && owner == 1'b0);
            elig1 = r1_valid && !(state == S_RESP && owner == 1'b1);
        end
        grant0    = elig0 && (!elig1 || last_grant);
        grant1    = elig1 && (!elig0 || !last_grant);
        accept    = grant0 || grant1;
        sel_write = grant1 ? r1_write : r0_write;
        sel_addr  = grant1 ? r1_addr  : r0_addr;
        sel_wdata = grant1 ? r1_wdata : r0_wdata;
    end

`ifdef APB_ARB_ADDR_CHECK_EN
    always_comb begin
        req_bad = 1'b1;
        if (sel_addr == ADDR_W'(32'h0) || sel_addr == ADDR_W'(32'h4) ||
            sel_addr == ADDR_W'(32'h8) || sel_addr == ADDR_W'(32'hC) ||
            sel_addr == ADDR_W'(32'h10))
            req_bad = 1'b0;
        if (sel_write && sel_addr == ADDR_W'(32'h4))
            req_bad = 1'b1;
    end
`endif

    always_ff @(posedge pclk) begin
        if (preset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_RESP: begin
                if (accept) begin
`ifdef APB_ARB_ADDR_CHECK_EN
                    next_state = req_bad ? S_ERR : S_SETUP;
`else
                    next_state = S_SETUP;
`endif
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_SETUP:   next_state = S_ACCESS;
            S_ACCESS:  next_state = S_CAPTURE;
            S_CAPTURE: next_state = S_RESP;
`ifdef APB_ARB_ADDR_CHECK_EN
            S_ERR:     next_state = S_RESP;
`endif
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        r0_ready     = grant0;
        r1_ready     = grant1;
        apb.psel     = (state == S_SETUP) || (state == S_ACCESS);
        apb.penable  = (state == S_ACCESS);
        r0_rsp_valid = (state == S_RESP) && (owner == 1'b0);
        r1_rsp_valid = (state == S_RESP) && (owner == 1'b1);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            apb.paddr  <= '0;
            apb.pwdata <= '0;
            apb.pwrite <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                apb.paddr  <= sel_addr;
                apb.pwrite <= sel_write;
                apb.pwdata <= sel_write ? sel_wdata : '0;
                owner      <= grant1;
                last_grant <= grant1;
            end
            // The slave has no pready: read data is only valid in CAPTURE.
            if (state == S_CAPTURE) begin
                rsp_rdata <= apb.pwrite ? '0 : apb.prdata;
                rsp_err   <= 1'b0;
            end
`ifdef APB_ARB_ADDR_CHECK_EN
            if (state == S_ERR) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - randomized bench for apb_req_arbiter against a transaction-level model
module tb_apb_req_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          pclk = 1'b0;
    logic          preset;
    logic          r0_valid, r0_write, r0_ready, r0_rsp_valid;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r1_valid, r1_write, r1_ready, r1_rsp_valid;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    always #5 pclk = ~pclk;

    apb_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

    apb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .pclk(pclk), .preset(preset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_write(r0_write),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rsp_valid(r0_rsp_valid),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_write(r1_write),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rsp_valid(r1_rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .apb(apb)
    );

    function automatic bit is_mapped(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a <= 32'h10);
    endfunction

    // register-file slave: read data appears the cycle after ACCESS, junk otherwise
    logic [31:0] slv_mem [0:4];
    always @(posedge pclk) begin
        if (apb.psel && apb.penable && !apb.pwrite)
            apb.prdata <= is_mapped(apb.paddr) ? slv_mem[apb.paddr[4:2]] : 32'h0;
        else
            apb.prdata <= $urandom;
        if (apb.psel && apb.penable && apb.pwrite && is_mapped(apb.paddr) && apb.paddr != 32'h4)
            slv_mem[apb.paddr[4:2]] <= apb.pwdata;
    end

    // transaction-level reference state
    int          cyc, rsp_at, t_hs;
    bit          live, owner_m, last_m, tx_err, tx_write, exp_err;
    logic [31:0] tx_addr, tx_pwdata, tx_rdata, exp_rdata;
    logic [31:0] model_mem [0:4];
    bit          skip_state, auto_clear;
    int          n_cmp, n_bad;
    logic [31:0] addr_tab [0:7];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        bit e0, e1, g0, g1, ev0, ev1, in_tx, bad, w;
        logic [31:0] a, d;
        #1;
        e0 = r0_valid && !preset && (cyc > rsp_at || (cyc == rsp_at && owner_m != 1'b0));
        e1 = r1_valid && !preset && (cyc > rsp_at || (cyc == rsp_at && owner_m != 1'b1));
        g0 = e0 && (!e1 || last_m);
        g1 = e1 && (!e0 || !last_m);
        check_eq("r0_ready", 32'(r0_ready), 32'(g0));
        check_eq("r1_ready", 32'(r1_ready), 32'(g1));
        if (!skip_state) begin
            ev0 = live && cyc == rsp_at && owner_m == 1'b0;
            ev1 = live && cyc == rsp_at && owner_m == 1'b1;
            if (ev0 || ev1) begin
                exp_rdata = tx_rdata;
                exp_err   = tx_err;
            end
            check_eq("r0_rsp_valid", 32'(r0_rsp_valid), 32'(ev0));
            check_eq("r1_rsp_valid", 32'(r1_rsp_valid), 32'(ev1));
            check_eq("rsp_rdata", rsp_rdata, exp_rdata);
            check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
            in_tx = live && !tx_err;
            check_eq("psel", 32'(apb.psel), 32'(in_tx && (cyc == t_hs + 1 || cyc == t_hs + 2)));
            check_eq("penable", 32'(apb.penable), 32'(in_tx && cyc == t_hs + 2));
            if (in_tx && cyc >= t_hs + 1 && cyc <= t_hs + 4) begin
                check_eq("paddr", apb.paddr, tx_addr);
                check_eq("pwrite", 32'(apb.pwrite), 32'(tx_write));
                check_eq("pwdata", apb.pwdata, tx_pwdata);
            end
        end
        if (preset) begin
            live = 0; rsp_at = -100; last_m = 1; exp_rdata = 0; exp_err = 0;
        end else if (g0 || g1) begin
            if (g1) begin w = r1_write; a = r1_addr; d = r1_wdata; end
            else    begin w = r0_write; a = r0_addr; d = r0_wdata; end
            bad = 0;
`ifdef APB_ARB_ADDR_CHECK_EN
            bad = !is_mapped(a) || (w && a == 32'h4);
`endif
            owner_m = g1; last_m = g1; t_hs = cyc; live = 1;
            tx_err = bad; tx_write = w; tx_addr = a;
            tx_pwdata = w ? d : 32'h0;
            rsp_at = cyc + (bad ? 2 : 4);
            if (bad || w) tx_rdata = 32'h0;
            else          tx_rdata = is_mapped(a) ? model_mem[a[4:2]] : 32'h0;
            if (!bad && w && is_mapped(a) && a != 32'h4) model_mem[a[4:2]] = d;
        end
        @(posedge pclk);
        @(negedge pclk);
        cyc++;
        skip_state = 0;
        if (auto_clear) begin
            if (g0) r0_valid = 0;
            if (g1) r1_valid = 0;
        end
    endtask

    task automatic set_req(input bit n, input bit w, input logic [31:0] a, input logic [31:0] d);
        if (n) begin r1_valid = 1; r1_write = w; r1_addr = a; r1_wdata = d; end
        else   begin r0_valid = 1; r0_write = w; r0_addr = a; r0_wdata = d; end
    endtask

    initial begin
        slv_mem[0] = 32'h0; slv_mem[1] = 32'h5A5A_0000; slv_mem[2] = 32'h0;
        slv_mem[3] = 32'hA5A5_0000; slv_mem[4] = 32'h0000_FFFF;
        for (int i = 0; i < 5; i++) model_mem[i] = slv_mem[i];
        addr_tab[0] = 32'h0;  addr_tab[1] = 32'h4;  addr_tab[2] = 32'h8;  addr_tab[3] = 32'hC;
        addr_tab[4] = 32'h10; addr_tab[5] = 32'h14; addr_tab[6] = 32'h20; addr_tab[7] = 32'h2;
        cyc = 0; rsp_at = -100; t_hs = -100; live = 0; owner_m = 0; last_m = 1;
        exp_rdata = 0; exp_err = 0; tx_err = 0; tx_write = 0;
        tx_addr = 0; tx_pwdata = 0; tx_rdata = 0;
        n_cmp = 0; n_bad = 0; skip_state = 1; auto_clear = 1;
        preset = 1;
        r0_valid = 0; r0_write = 0; r0_addr = 0; r0_wdata = 0;
        r1_valid = 0; r1_write = 0; r1_addr = 0; r1_wdata = 0;

        repeat (3) step();
        preset = 0;
        repeat (3) step();

        set_req(0, 1, 32'h8, 32'hDEAD_BEEF);
        repeat (6) step();
        set_req(0, 0, 32'h8, 32'h0);
        repeat (6) step();

        auto_clear = 0;
        set_req(0, 0, 32'hC, 32'h0);
        set_req(1, 0, 32'h10, 32'h0);
        repeat (17) step();
        r0_valid = 0; r1_valid = 0; auto_clear = 1;
        repeat (6) step();

        // reset lands while the read is in ACCESS
        set_req(0, 0, 32'h8, 32'h0);
        step();
        step();
        preset = 1;
        step();
        preset = 0;
        repeat (6) step();

        set_req(0, 0, 32'h10, 32'h0);
        set_req(1, 0, 32'hC, 32'h0);
        repeat (10) step();

        set_req(1, 1, 32'h4, 32'h1234_5678);
        repeat (6) step();
        set_req(1, 0, 32'h4, 32'h0);
        repeat (6) step();
        set_req(0, 0, 32'h20, 32'h0);
        repeat (6) step();

        for (int k = 0; k < 1500; k++) begin
            if (!r0_valid) begin
                if ($urandom_range(2) == 0)
                    set_req(0, 1'($urandom_range(1)), addr_tab[$urandom_range(7)], $urandom);
            end else if ($urandom_range(19) == 0) begin
                r0_valid = 0;
            end
            if (!r1_valid) begin
                if ($urandom_range(2) == 0)
                    set_req(1, 1'($urandom_range(1)), addr_tab[$urandom_range(7)], $urandom);
            end else if ($urandom_range(19) == 0) begin
                r1_valid = 0;
            end
            step();
        end
        r0_valid = 0; r1_valid = 0;
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
